// File: rtl/bka_sub_pipe.sv
// bka_sub_pipe: three-stage pipelined Brent-Kung subtractor.
//   diff = a - b - bin (mod 2^WIDTH), computed as a + ~b + ~bin through a
//   Brent-Kung generate/propagate prefix tree.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready operand handshake (a, b, bin)
//   out_valid/out_ready result handshake (diff, bout, ovf, zero)
//   bout = 1 when unsigned a < b + bin; ovf = signed overflow; zero = diff==0
module bka_sub_pipe #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);

   localparam int LG = $clog2(WIDTH);

   // stage 1: pre-processed operands
   logic             v1;
   logic [WIDTH-1:0] p1, g1;
   logic             cin1, am1, bm1;

   // stage 2: carries and propagate
   logic             v2;
   logic [WIDTH:0]   c2;
   logic [WIDTH-1:0] p2;
   logic             am2, bm2;

   // stage 3 state is the output registers themselves
   logic             v3;

   logic free1, free2, free3;

   // A stage may load when it is empty or its content moves on this edge.
   // The chain runs backwards from out_ready only, so in_valid never reaches in_ready.
   assign free3    = !v3 || out_ready;
   assign free2    = !v2 || free3;
   assign free1    = !v1 || free2;
   assign in_ready = free1;
   assign out_valid = v3;

   // Brent-Kung prefix over (g, p) with the carry-in folded into bit 0,
   // so gg[i] after both sweeps is the carry out of bit i.
   logic [WIDTH-1:0] gg, pp;
   logic [WIDTH:0]   c_pre;

   always_comb begin
      gg    = g1;
      pp    = p1;
      gg[0] = g1[0] | (p1[0] & cin1);
      // up-sweep: build power-of-two spans ending at i
      for (int l = 0; l < LG; l++) begin
         for (int i = (2 << l) - 1; i < WIDTH; i += (2 << l)) begin
            gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
            pp[i] = pp[i] & pp[i - (1 << l)];
         end
      end
      // down-sweep: fill in the remaining positions from completed spans
      for (int l = LG - 2; l >= 0; l--) begin
         for (int i = 3 * (1 << l) - 1; i < WIDTH; i += (2 << l)) begin
            gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
            pp[i] = pp[i] & pp[i - (1 << l)];
         end
      end
      c_pre = {gg, cin1};
   end

   logic [WIDTH-1:0] diff_n;
   assign diff_n = p2 ^ c2[WIDTH-1:0];

   // data registers of stages 1 and 2 carry no reset; their valid bits guard them
   always_ff @(posedge clk) begin
      if (free1) begin
         p1   <= a ^ ~b;
         g1   <= a & ~b;
         cin1 <= ~bin;
         am1  <= a[WIDTH-1];
         bm1  <= b[WIDTH-1];
      end
      if (free2) begin
         c2  <= c_pre;
         p2  <= p1;
         am2 <= am1;
         bm2 <= bm1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1   <= 1'b0;
         v2   <= 1'b0;
         v3   <= 1'b0;
         diff <= '0;
         bout <= 1'b0;
         ovf  <= 1'b0;
         zero <= 1'b0;
      end else begin
         if (free1) v1 <= in_valid;
         if (free2) v2 <= v1;
         if (free3) v3 <= v2;
         if (free3 && v2) begin
            diff <= diff_n;
            bout <= ~c2[WIDTH];
            ovf  <= (am2 != bm2) && (diff_n[WIDTH-1] != am2);
            zero <= ~|diff_n;
         end
      end
   end

endmodule

// File: tb/tb_bka_sub_pipe.sv
// tb_bka_sub_pipe: directed and random checks of bka_sub_pipe (WIDTH = 16).
module tb_bka_sub_pipe;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a, b;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         bout, ovf, zero;

   bka_sub_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin),
      .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int emitted = 0;
   int accepted = 0;

   logic [W+2:0] q[$];   // expected {diff, bout, ovf, zero}

   function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mbin);
      logic [W:0]   full;
      logic [W-1:0] d;
      logic         o;
      full = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
      d    = full[W-1:0];
      o    = (ma[W-1] != mb[W-1]) && (d[W-1] != ma[W-1]);
      return {d, full[W], o, (d == '0)};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One streaming cycle: drive inputs, score any output transfer, record any input transfer.
   task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ibin, input logic ordy, output logic acc);
      logic [W+2:0] e;
      in_valid  = iv;
      a         = ia;
      b         = ib;
      bin       = ibin;
      out_ready = ordy;
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
         emitted++;
         check("no_extra_result", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            check("stream_result", 32'({diff, bout, ovf, zero}), 32'(e));
         end
      end
      if (acc) begin
         accepted++;
         q.push_back(model(ia, ib, ibin));
      end
      tick();
   endtask

   // Present one operand set with out_ready high; result must appear exactly 3 cycles later.
   task automatic single(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ibin, input logic [W-1:0] ed, input logic eb,
                         input logic eo, input logic ez);
      in_valid  = 1'b1;
      a         = ia;
      b         = ib;
      bin       = ibin;
      out_ready = 1'b1;
      #1;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check({tag, "_early1"}, 32'(out_valid), 32'd0);
      tick();
      check({tag, "_early2"}, 32'(out_valid), 32'd0);
      tick();
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_diff"}, 32'(diff), 32'(ed));
      check({tag, "_bout"}, 32'(bout), 32'(eb));
      check({tag, "_ovf"}, 32'(ovf), 32'(eo));
      check({tag, "_zero"}, 32'(zero), 32'(ez));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   logic [W-1:0] bp_a[6] = '{16'h0010, 16'h0003, 16'h8000, 16'h1234, 16'hFFFF, 16'h0000};
   logic [W-1:0] bp_b[6] = '{16'h0001, 16'h0005, 16'h0001, 16'h1234, 16'h0001, 16'h0000};
   logic         bp_c[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      logic         acc;
      logic [W+2:0] held;
      int           idx;

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_flags", 32'({bout, ovf, zero}), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      single("sub_small", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
      single("sub_neg",   16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0);
      single("sub_bin",   16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      single("ovf_pos",   16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
      single("ovf_neg",   16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
      single("zero",      16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);

      // drain the last directed result
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      check("drained", 32'(out_valid), 32'd0);

      // backpressure: 6 back-to-back operands, out_ready low for the first 5 cycles
      out_ready = 1'b0;
      idx = 0; emitted = 0; accepted = 0; held = '0;
      for (int c = 0; c < 40 && (idx < 6 || q.size() != 0); c++) begin
         if (c == 3 || c == 4) begin
            check("bp_full_in_ready", 32'(in_ready), 32'd0);
            check("bp_full_valid", 32'(out_valid), 32'd1);
         end
         if (c == 3) held = {diff, bout, ovf, zero};
         if (c == 4 || c == 5) check("bp_held", 32'({diff, bout, ovf, zero}), 32'(held));
         cycle(idx < 6, bp_a[idx % 6], bp_b[idx % 6], bp_c[idx % 6], c >= 5, acc);
         if (acc) idx++;
      end
      check("bp_accepted", 32'(accepted), 32'd6);
      check("bp_emitted", 32'(emitted), 32'd6);
      check("bp_queue_empty", 32'(q.size()), 32'd0);

      // random stream with random backpressure
      emitted = 0; accepted = 0;
      for (int i = 0; i < 1000; i++) begin
         cycle(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) != 0), acc);
      end
      for (int i = 0; i < 20 && q.size() != 0; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
      check("rnd_queue_empty", 32'(q.size()), 32'd0);
      check("rnd_counts", 32'(emitted), 32'(accepted));

      // reset with three results in flight
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) cycle(1'b1, 16'(16'h0100 + i), 16'h0001, 1'b0, 1'b0, acc);
      check("pre_rst_full", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      q.delete();
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      single("post_rst", 16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b1;
      tick();
      check("post_rst_no_extra", 32'(out_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
